// File: rtl/iob_bus_arbiter_if.sv
// iob_bus_arbiter_if
//   Native valid/ready bus bundle for the two-master / one-slave arbiter.
//   m0_* / m1_* : requesting masters (instruction bus, data bus)
//                 valid/addr/wdata/wstrb toward the arbiter, rdata/ready back
//   s_*         : shared slave port (valid/addr/wdata/wstrb out, rdata/ready in)
//   Modports:
//     master - the arbiter's view: it masters the shared slave port and
//              answers both requesting masters.
//     slave  - the surrounding system's view (masters plus memory).
interface iob_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  m0_valid;
    logic [ADDR_W-1:0]     m0_addr;
    logic [DATA_W-1:0]     m0_wdata;
    logic [DATA_W/8-1:0]   m0_wstrb;
    logic [DATA_W-1:0]     m0_rdata;
    logic                  m0_ready;

    logic                  m1_valid;
    logic [ADDR_W-1:0]     m1_addr;
    logic [DATA_W-1:0]     m1_wdata;
    logic [DATA_W/8-1:0]   m1_wstrb;
    logic [DATA_W-1:0]     m1_rdata;
    logic                  m1_ready;

    logic                  s_valid;
    logic [ADDR_W-1:0]     s_addr;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic [DATA_W-1:0]     s_rdata;
    logic                  s_ready;

    modport master (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_rdata, m0_ready,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_rdata, m1_ready,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ready
    );

    modport slave (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_rdata, m0_ready,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_rdata, m1_ready,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ready
    );
endinterface

// File: rtl/iob_bus_arbiter.sv
// iob_bus_arbiter
//   Two-master / one-slave arbiter for the native valid/ready memory bus.
//   The grant is held for one whole transaction; ties are resolved
//   round-robin (FIXED_PRIO=0) or always in favour of master 1.
//   A watchdog completes a stalled transaction with ERR_DATA.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     bus         : master/slave bundle (iob_bus_arbiter_if.master)
//     busy        : high while a transaction is in flight
//     owner       : current or last granted master
//     timeout     : one-cycle pulse when the watchdog fires
//     err_cnt     : saturating count of watchdog timeouts
module iob_bus_arbiter #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIXED_PRIO = 0,
    parameter int unsigned       TIMEOUT_W  = 8,
    parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                resetn,
    iob_bus_arbiter_if.master   bus,
    output logic                busy,
    output logic                owner,
    output logic                timeout,
    output logic [7:0]          err_cnt
);
    localparam int unsigned CW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic              in_busy;
    logic              own_valid;
    logic              expire;
    logic              done;
    logic [DATA_W-1:0] rsp_data;

    // Datapath: live mux of the owner onto the slave port, responses
    // routed back with no added latency.
    always_comb begin
        in_busy   = (state_q == BUSY);
        own_valid = owner_q ? bus.m1_valid : bus.m0_valid;
        // A slave answer in the expiry cycle wins over the watchdog.
        expire    = (TIMEOUT_W != 0) && in_busy && own_valid &&
                    !bus.s_ready && (cnt_q == CNT_MAX);
        // An owner that drops valid mid-transaction gets no ready.
        done      = in_busy && own_valid && (bus.s_ready || expire);
        rsp_data  = expire ? ERR_DATA : bus.s_rdata;

        bus.s_valid = in_busy && own_valid && !expire;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        if (in_busy) begin
            bus.s_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
            bus.s_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
            bus.s_wstrb = owner_q ? bus.m1_wstrb : bus.m0_wstrb;
        end

        bus.m0_ready = done && !owner_q;
        bus.m1_ready = done &&  owner_q;
        bus.m0_rdata = (in_busy && !owner_q) ? rsp_data : '0;
        bus.m1_rdata = (in_busy &&  owner_q) ? rsp_data : '0;
        timeout      = expire;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.m0_valid || bus.m1_valid) begin
                    state_d = BUSY;
                    if (bus.m0_valid && bus.m1_valid)
                        owner_d = (FIXED_PRIO != 0) ? 1'b1 : !owner_q;
                    else
                        owner_d = bus.m1_valid;
                end
            end
            BUSY: begin
                if (!own_valid || bus.s_ready || expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (expire && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy    = in_busy;
    assign owner   = owner_q;
    assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_iob_bus_arbiter.sv
// tb_iob_bus_arbiter
//   Table-driven check of a round-robin arbiter instance plus hand-written
//   sequences for fixed priority, watchdog expiry and mid-transaction reset.
module tb_iob_bus_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic       rr_busy, rr_owner, rr_timeout, fp_busy, fp_owner, fp_timeout;
    logic [7:0] rr_err_cnt, fp_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iob_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_rr ();
    iob_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_fp ();

    assign bus_rr.m0_valid = m0_valid;  assign bus_fp.m0_valid = m0_valid;
    assign bus_rr.m0_addr  = m0_addr;   assign bus_fp.m0_addr  = m0_addr;
    assign bus_rr.m0_wdata = m0_wdata;  assign bus_fp.m0_wdata = m0_wdata;
    assign bus_rr.m0_wstrb = m0_wstrb;  assign bus_fp.m0_wstrb = m0_wstrb;
    assign bus_rr.m1_valid = m1_valid;  assign bus_fp.m1_valid = m1_valid;
    assign bus_rr.m1_addr  = m1_addr;   assign bus_fp.m1_addr  = m1_addr;
    assign bus_rr.m1_wdata = m1_wdata;  assign bus_fp.m1_wdata = m1_wdata;
    assign bus_rr.m1_wstrb = m1_wstrb;  assign bus_fp.m1_wstrb = m1_wstrb;
    assign bus_rr.s_rdata  = s_rdata;   assign bus_fp.s_rdata  = s_rdata;
    assign bus_rr.s_ready  = s_ready;   assign bus_fp.s_ready  = s_ready;

    iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_W(4)) u_rr (
        .clk(clk), .resetn(resetn), .bus(bus_rr), .busy(rr_busy),
        .owner(rr_owner), .timeout(rr_timeout), .err_cnt(rr_err_cnt)
    );

    iob_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_W(4)) u_fp (
        .clk(clk), .resetn(resetn), .bus(bus_fp), .busy(fp_busy),
        .owner(fp_owner), .timeout(fp_timeout), .err_cnt(fp_err_cnt)
    );

    typedef struct {
        logic [31:0] m0v, m0a, m1v, m1a, m1wd, m1ws, srd, srdy;
        logic [31:0] sv, sa, swd, sws, r0, d0, r1, d1, bsy, own;
    } vec_t;

    localparam int unsigned NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_rdata = '0; s_ready = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        zero_inputs();
        #2;
        chk("rst busy",    32'(rr_busy),        32'd0);
        chk("rst owner",   32'(rr_owner),       32'd1);
        chk("rst err_cnt", 32'(rr_err_cnt),     32'd0);
        chk("rst timeout", 32'(rr_timeout),     32'd0);
        chk("rst s_valid", 32'(bus_rr.s_valid), 32'd0);
        chk("rst s_addr",  bus_rr.s_addr,       32'd0);
        chk("rst fp owner", 32'(fp_owner),      32'd1);
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        //            m0v m0a       m1v m1a       m1wd          m1ws srd           srdy | sv sa        swd           sws r0 d0            r1 d1       bsy own
        // Both requesting, round-robin from reset (last_grant=1 -> m0 first)
        vecs[0]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        vecs[1]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 32'h11,       1,   1, 32'hA0,   0,            0, 1, 32'h11,       0, 0,       1, 0};
        vecs[2]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 0};
        vecs[3]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 32'h22,       1,   1, 32'hB0,   0,            0, 0, 0,            1, 32'h22,  1, 1};
        vecs[4]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        vecs[5]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 32'h33,       1,   1, 32'hA0,   0,            0, 1, 32'h33,       0, 0,       1, 0};
        vecs[6]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 0};
        vecs[7]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 32'h77,       0,   1, 32'hB0,   0,            0, 0, 0,            0, 32'h77,  1, 1};
        vecs[8]  = '{1, 32'hA0,  1, 32'hB0,  0,            0, 32'h44,       1,   1, 32'hB0,   0,            0, 0, 0,            1, 32'h44,  1, 1};
        vecs[9]  = '{0, 0,       0, 0,       0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        // Single m0 read at 0x100, slave answers in the third BUSY cycle
        vecs[10] = '{1, 32'h100, 0, 0,       0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        vecs[11] = '{1, 32'h100, 0, 0,       0,            0, 0,            0,   1, 32'h100,  0,            0, 0, 0,            0, 0,       1, 0};
        vecs[12] = '{1, 32'h100, 0, 0,       0,            0, 0,            0,   1, 32'h100,  0,            0, 0, 0,            0, 0,       1, 0};
        vecs[13] = '{1, 32'h100, 0, 0,       0,            0, 32'h12345678, 1,   1, 32'h100,  0,            0, 1, 32'h12345678, 0, 0,       1, 0};
        // Late s_ready in IDLE is not forwarded
        vecs[14] = '{0, 0,       0, 0,       0,            0, 32'h55,       1,   0, 0,        0,            0, 0, 0,            0, 0,       0, 0};
        // m1 write 0xA5A5A5A5, wstrb 0011, addr 0x2004
        vecs[15] = '{0, 0,       1, 32'h2004, 32'hA5A5A5A5, 3, 0,           0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 0};
        vecs[16] = '{0, 0,       1, 32'h2004, 32'hA5A5A5A5, 3, 0,           0,   1, 32'h2004, 32'hA5A5A5A5, 3, 0, 0,            0, 0,       1, 1};
        vecs[17] = '{0, 0,       1, 32'h2004, 32'hA5A5A5A5, 3, 0,           1,   1, 32'h2004, 32'hA5A5A5A5, 3, 0, 0,            1, 0,       1, 1};
        vecs[18] = '{0, 0,       0, 0,       0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        // Owner drops valid while BUSY: no ready, back to IDLE
        vecs[19] = '{1, 32'h300, 0, 0,       0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 1};
        vecs[20] = '{1, 32'h300, 0, 0,       0,            0, 0,            0,   1, 32'h300,  0,            0, 0, 0,            0, 0,       1, 0};
        vecs[21] = '{0, 32'h300, 0, 0,       0,            0, 0,            0,   0, 32'h300,  0,            0, 0, 0,            0, 0,       1, 0};
        vecs[22] = '{0, 0,       0, 0,       0,            0, 0,            0,   0, 0,        0,            0, 0, 0,            0, 0,       0, 0};

        zero_inputs();
        do_reset();

        for (int unsigned i = 0; i < NV; i++) begin
            tick();
            m0_valid = vecs[i].m0v[0];
            m0_addr  = vecs[i].m0a;
            m1_valid = vecs[i].m1v[0];
            m1_addr  = vecs[i].m1a;
            m1_wdata = vecs[i].m1wd;
            m1_wstrb = vecs[i].m1ws[3:0];
            s_rdata  = vecs[i].srd;
            s_ready  = vecs[i].srdy[0];
            #2;
            chk($sformatf("row%0d s_valid", i),  32'(bus_rr.s_valid),  vecs[i].sv);
            chk($sformatf("row%0d s_addr", i),   bus_rr.s_addr,        vecs[i].sa);
            chk($sformatf("row%0d s_wdata", i),  bus_rr.s_wdata,       vecs[i].swd);
            chk($sformatf("row%0d s_wstrb", i),  32'(bus_rr.s_wstrb),  vecs[i].sws);
            chk($sformatf("row%0d m0_ready", i), 32'(bus_rr.m0_ready), vecs[i].r0);
            chk($sformatf("row%0d m0_rdata", i), bus_rr.m0_rdata,      vecs[i].d0);
            chk($sformatf("row%0d m1_ready", i), 32'(bus_rr.m1_ready), vecs[i].r1);
            chk($sformatf("row%0d m1_rdata", i), bus_rr.m1_rdata,      vecs[i].d1);
            chk($sformatf("row%0d busy", i),     32'(rr_busy),         vecs[i].bsy);
            chk($sformatf("row%0d owner", i),    32'(rr_owner),        vecs[i].own);
        end
        chk("violation err_cnt", 32'(rr_err_cnt), 32'd0);

        // Fixed priority: m1 wins every tie; m0 only when m1 is idle at IDLE
        do_reset();
        tick();
        m0_valid = 1'b1; m0_addr = 32'hC0;
        m1_valid = 1'b1; m1_addr = 32'hD0;
        #2;
        chk("fp idle busy", 32'(fp_busy), 32'd0);
        for (int rep = 0; rep < 3; rep++) begin
            tick();
            s_ready = 1'b1; s_rdata = 32'(rep + 1);
            #2;
            chk($sformatf("fp%0d owner", rep),    32'(fp_owner),        32'd1);
            chk($sformatf("fp%0d m1_ready", rep), 32'(bus_fp.m1_ready), 32'd1);
            chk($sformatf("fp%0d m1_rdata", rep), bus_fp.m1_rdata,      32'(rep + 1));
            chk($sformatf("fp%0d m0_ready", rep), 32'(bus_fp.m0_ready), 32'd0);
            tick();
            s_ready = 1'b0;
            m1_valid = (rep < 2);
            #2;
            chk($sformatf("fp%0d bubble", rep), 32'(bus_fp.s_valid), 32'd0);
        end
        tick();
        s_ready = 1'b1; s_rdata = 32'h99;
        #2;
        chk("fp m0 owner",    32'(fp_owner),        32'd0);
        chk("fp m0 s_addr",   bus_fp.s_addr,        32'hC0);
        chk("fp m0_ready",    32'(bus_fp.m0_ready), 32'd1);
        tick();
        zero_inputs();

        // Watchdog: slave never answers, fires in BUSY cycle 15
        do_reset();
        tick();
        m0_valid = 1'b1; m0_addr = 32'h40;
        #2;
        for (int k = 0; k < 15; k++) begin
            tick();
            #2;
            chk($sformatf("wd%0d timeout", k),  32'(rr_timeout),       32'd0);
            chk($sformatf("wd%0d m0_ready", k), 32'(bus_rr.m0_ready),  32'd0);
            chk($sformatf("wd%0d s_valid", k),  32'(bus_rr.s_valid),   32'd1);
        end
        tick();
        #2;
        chk("wd fire timeout",  32'(rr_timeout),       32'd1);
        chk("wd fire m0_ready", 32'(bus_rr.m0_ready),  32'd1);
        chk("wd fire m0_rdata", bus_rr.m0_rdata,       32'hDEADBEEF);
        chk("wd fire s_valid",  32'(bus_rr.s_valid),   32'd0);
        chk("wd fire m1_ready", 32'(bus_rr.m1_ready),  32'd0);
        tick();
        m0_valid = 1'b0;
        #2;
        chk("wd after busy",    32'(rr_busy),    32'd0);
        chk("wd after timeout", 32'(rr_timeout), 32'd0);
        chk("wd after err_cnt", 32'(rr_err_cnt), 32'd1);

        // Same stall, but the slave answers in the expiry cycle
        do_reset();
        tick();
        m0_valid = 1'b1; m0_addr = 32'h44;
        #2;
        for (int k = 0; k < 15; k++) tick();
        tick();
        s_ready = 1'b1; s_rdata = 32'h00C0FFEE;
        #2;
        chk("wd race timeout",  32'(rr_timeout),      32'd0);
        chk("wd race m0_ready", 32'(bus_rr.m0_ready), 32'd1);
        chk("wd race m0_rdata", bus_rr.m0_rdata,      32'h00C0FFEE);
        chk("wd race s_valid",  32'(bus_rr.s_valid),  32'd1);
        tick();
        zero_inputs();
        #2;
        chk("wd race err_cnt", 32'(rr_err_cnt), 32'd0);
        chk("wd race busy",    32'(rr_busy),    32'd0);

        // Reset while BUSY on m1, then a fresh m0 transaction
        do_reset();
        tick();
        m1_valid = 1'b1; m1_addr = 32'h80;
        #2;
        tick();
        #2;
        chk("mid busy",    32'(rr_busy),        32'd1);
        chk("mid s_valid", 32'(bus_rr.s_valid), 32'd1);
        chk("mid owner",   32'(rr_owner),       32'd1);
        #1;
        resetn = 1'b0;
        s_ready = 1'b1;
        #1;
        chk("rst mid s_valid",  32'(bus_rr.s_valid),  32'd0);
        chk("rst mid busy",     32'(rr_busy),         32'd0);
        chk("rst mid m1_ready", 32'(bus_rr.m1_ready), 32'd0);
        chk("rst mid m0_ready", 32'(bus_rr.m0_ready), 32'd0);
        chk("rst mid owner",    32'(rr_owner),        32'd1);
        tick();
        zero_inputs();
        tick();
        resetn = 1'b1;
        tick();
        m0_valid = 1'b1; m0_addr = 32'h90;
        #2;
        chk("post idle busy", 32'(rr_busy), 32'd0);
        tick();
        #2;
        chk("post s_valid", 32'(bus_rr.s_valid), 32'd1);
        chk("post s_addr",  bus_rr.s_addr,        32'h90);
        chk("post owner",   32'(rr_owner),        32'd0);
        tick();
        s_ready = 1'b1; s_rdata = 32'hABCD;
        #2;
        chk("post m0_ready", 32'(bus_rr.m0_ready), 32'd1);
        chk("post m0_rdata", bus_rr.m0_rdata,      32'hABCD);
        tick();
        zero_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
